branch_resolve_unit: RTL and testbench

//  Multi-lane, registered branch resolution stage for the superscalar core; sits after issue/operand read.

---
 rtl/branch_resolve_unit.sv | 191 +++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Multi-lane registered branch resolution: evaluates control ops, flags the oldest
// mispredict as a redirect, squashes younger lanes and drains the wrong path.
module branch_resolve_unit #(
    parameter int XLEN       = 32,
    parameter int LANES      = 2,
    parameter int ALUCODE_W  = 6,
    parameter int SQUASH_CYC = 1,
    parameter int CNT_W      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic [LANES-1:0]           in_valid,
    input  logic [LANES*ALUCODE_W-1:0] in_alucode,
    input  logic [LANES*XLEN-1:0]      in_op1,
    input  logic [LANES*XLEN-1:0]      in_op2,
    input  logic [LANES*XLEN-1:0]      in_pc,
    input  logic [LANES*XLEN-1:0]      in_target,
    input  logic [LANES-1:0]           in_pred_taken,
    input  logic [LANES*XLEN-1:0]      in_pred_target,
    output logic                       in_ready,
    output logic [LANES-1:0]           out_valid,
    output logic [LANES-1:0]           out_taken,
    output logic                       redirect_valid,
    output logic [XLEN-1:0]            redirect_pc,
    output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] redirect_lane,
    output logic [CNT_W-1:0]           br_count,
    output logic [CNT_W-1:0]           mispred_count
);

    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SQ_W  = $clog2(SQUASH_CYC + 1);
    localparam int INC_W = $clog2(LANES + 1);

    localparam logic [ALUCODE_W-1:0] ALU_BEQ  = ALUCODE_W'(10);
    localparam logic [ALUCODE_W-1:0] ALU_BNE  = ALUCODE_W'(11);
    localparam logic [ALUCODE_W-1:0] ALU_BLT  = ALUCODE_W'(12);
    localparam logic [ALUCODE_W-1:0] ALU_BGE  = ALUCODE_W'(13);
    localparam logic [ALUCODE_W-1:0] ALU_BLTU = ALUCODE_W'(14);
    localparam logic [ALUCODE_W-1:0] ALU_BGEU = ALUCODE_W'(15);
    localparam logic [ALUCODE_W-1:0] ALU_JAL  = ALUCODE_W'(16);
    localparam logic [ALUCODE_W-1:0] ALU_JALR = ALUCODE_W'(17);

    typedef enum logic {RUN, SQUASH} state_t;

    state_t            state;
    logic [SQ_W-1:0]   sq_cnt;

    logic [LANES-1:0]  is_ctrl;
    logic [LANES-1:0]  taken;
    logic [LANES-1:0]  mispred;
    logic [XLEN-1:0]   next_pc [LANES];

    logic              found;
    logic [LANES-1:0]  surv;
    logic [LW-1:0]     m_lane;
    logic [XLEN-1:0]   m_pc;
    logic [INC_W-1:0]  inc;

    logic              accept;
    logic [CNT_W:0]    br_sum;
    logic [CNT_W-1:0]  br_next;
    logic [CNT_W-1:0]  mis_next;

    assign in_ready = !stall && (state == RUN);
    assign accept   = in_ready;

    // Per-lane outcome, actual next PC and mispredict flag.
    always_comb begin
        // NOTE: every output of a combinational block gets a default up front so no path can infer a latch.
        is_ctrl = '0;
        taken   = '0;
        mispred = '0;
        for (int i = 0; i < LANES; i++) begin
            next_pc[i] = '0;
            case (in_alucode[i*ALUCODE_W +: ALUCODE_W])
                ALU_BEQ: begin
                    is_ctrl[i] = 1'b1;
                    taken[i]   = in_op1[i*XLEN +: XLEN] == in_op2[i*XLEN +: XLEN];
                end
                ALU_BNE: begin
                    is_ctrl[i] = 1'b1;
                    taken[i]   = in_op1[i*XLEN +: XLEN] != in_op2[i*XLEN +: XLEN];
                end
                ALU_BLT: begin
                    is_ctrl[i] = 1'b1;
                    taken[i]   = $signed(in_op1[i*XLEN +: XLEN]) < $signed(in_op2[i*XLEN +: XLEN]);
                end
                ALU_BGE: begin
                    is_ctrl[i] = 1'b1;
                    taken[i]   = $signed(in_op1[i*XLEN +: XLEN]) >= $signed(in_op2[i*XLEN +: XLEN]);
                end
                ALU_BLTU: begin
                    is_ctrl[i] = 1'b1;
                    taken[i]   = in_op1[i*XLEN +: XLEN] < in_op2[i*XLEN +: XLEN];
                end
                ALU_BGEU: begin
                    is_ctrl[i] = 1'b1;
                    taken[i]   = in_op1[i*XLEN +: XLEN] >= in_op2[i*XLEN +: XLEN];
                end
                ALU_JAL, ALU_JALR: begin
                    is_ctrl[i] = 1'b1;
                    taken[i]   = 1'b1;
                end
                default: ;
            endcase
            next_pc[i] = taken[i] ? in_target[i*XLEN +: XLEN]
                                  : in_pc[i*XLEN +: XLEN] + XLEN'(4);
            mispred[i] = in_valid[i] &&
                         ((in_pred_taken[i] != taken[i]) ||
                          (taken[i] && (in_pred_target[i*XLEN +: XLEN] != in_target[i*XLEN +: XLEN])));
        end
    end

    // Oldest mispredict wins; everything younger than it is squashed.
    always_comb begin
        found  = 1'b0;
        surv   = '0;
        m_lane = '0;
        m_pc   = '0;
        inc    = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!found) begin
                surv[i] = in_valid[i];
                if (mispred[i]) begin
                    found  = 1'b1;
                    m_lane = LW'(i);
                    m_pc   = next_pc[i];
                end
            end
            if (surv[i] && is_ctrl[i]) begin
                inc = inc + INC_W'(1);
            end
        end
    end

    assign br_sum   = {1'b0, br_count} + (CNT_W+1)'(inc);
    assign br_next  = br_sum[CNT_W] ? {CNT_W{1'b1}} : br_sum[CNT_W-1:0];
    assign mis_next = (&mispred_count) ? mispred_count : mispred_count + CNT_W'(1);

    // NOTE: state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RUN;
            sq_cnt         <= '0;
            out_valid      <= '0;
            out_taken      <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            redirect_lane  <= '0;
            br_count       <= '0;
            mispred_count  <= '0;
        end else begin
            out_valid      <= '0;
            out_taken      <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            redirect_lane  <= '0;

            if (accept) begin
                out_valid      <= surv;
                out_taken      <= taken & in_valid;
                redirect_valid <= found;
                redirect_pc    <= m_pc;
                redirect_lane  <= m_lane;
                br_count       <= br_next;
                if (found) begin
                    mispred_count <= mis_next;
                end
            end

            case (state)
                RUN: begin
                    if (accept && found) begin
                        state  <= SQUASH;
                        sq_cnt <= SQ_W'(SQUASH_CYC);
                    end
                end
                SQUASH: begin
                    // Input is refused for exactly SQUASH_CYC cycles, regardless of stall.
                    sq_cnt <= sq_cnt - SQ_W'(1);
                    if (sq_cnt <= SQ_W'(1)) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: LANES=2, SQUASH_CYC=2, CNT_W=4 so saturation is reachable.
module tb_branch_resolve_unit;

    localparam int XLEN = 32;
    localparam int LANES = 2;
    localparam int AW = 6;
    localparam int SQC = 2;
    localparam int CW = 4;

    localparam logic [5:0] BEQ  = 6'd10;
    localparam logic [5:0] BNE  = 6'd11;
    localparam logic [5:0] BLT  = 6'd12;
    localparam logic [5:0] BGE  = 6'd13;
    localparam logic [5:0] BLTU = 6'd14;
    localparam logic [5:0] BGEU = 6'd15;
    localparam logic [5:0] JAL  = 6'd16;
    localparam logic [5:0] JALR = 6'd17;
    localparam logic [5:0] ADD  = 6'd0;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  stall;
    logic [LANES-1:0]      in_valid;
    logic [LANES*AW-1:0]   in_alucode;
    logic [LANES*XLEN-1:0] in_op1, in_op2, in_pc, in_target, in_pred_target;
    logic [LANES-1:0]      in_pred_taken;
    logic                  in_ready;
    logic [LANES-1:0]      out_valid, out_taken;
    logic                  redirect_valid;
    logic [XLEN-1:0]       redirect_pc;
    logic [0:0]            redirect_lane;
    logic [CW-1:0]         br_count, mispred_count;

    int n_cmp = 0;
    int n_err = 0;

    branch_resolve_unit #(
        .XLEN(XLEN), .LANES(LANES), .ALUCODE_W(AW), .SQUASH_CYC(SQC), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .in_valid(in_valid), .in_alucode(in_alucode),
        .in_op1(in_op1), .in_op2(in_op2), .in_pc(in_pc), .in_target(in_target),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
        .in_ready(in_ready), .out_valid(out_valid), .out_taken(out_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_lane(redirect_lane), .br_count(br_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int l, input logic [5:0] code, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] pc, input logic [31:0] tgt,
                            input logic pt, input logic [31:0] ptgt, input logic v);
        in_valid[l]                 = v;
        in_alucode[l*AW +: AW]      = code;
        in_op1[l*XLEN +: XLEN]      = a;
        in_op2[l*XLEN +: XLEN]      = b;
        in_pc[l*XLEN +: XLEN]       = pc;
        in_target[l*XLEN +: XLEN]   = tgt;
        in_pred_taken[l]            = pt;
        in_pred_target[l*XLEN +: XLEN] = ptgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare all result outputs after an edge; taken is only meaningful on surviving lanes.
    task automatic check_out(input string tag, input logic [1:0] ov, input logic [1:0] ot,
                             input logic rv, input logic [31:0] rpc, input logic rl,
                             input logic [3:0] bc, input logic [3:0] mc);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        check({tag, ".out_taken"}, 32'(out_taken & ov), 32'(ot));
        check({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(rv));
        check({tag, ".redirect_pc"}, redirect_pc, rpc);
        check({tag, ".redirect_lane"}, 32'(redirect_lane), 32'(rl));
        check({tag, ".br_count"}, 32'(br_count), 32'(bc));
        check({tag, ".mispred_count"}, 32'(mispred_count), 32'(mc));
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        in_valid = '0; in_alucode = '0; in_op1 = '0; in_op2 = '0;
        in_pc = '0; in_target = '0; in_pred_taken = '0; in_pred_target = '0;
        tick();
        tick();
        rst = 1'b0;
        check_out("reset", 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 4'd0, 4'd0);
        check("reset.in_ready", 32'(in_ready), 32'd1);

        // 1: correctly predicted taken BEQ on lane 0
        set_lane(0, BEQ, 32'd5, 32'd5, 32'h40, 32'h100, 1'b1, 32'h100, 1'b1);
        set_lane(1, ADD, 32'd0, 32'd0, 32'h44, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        check_out("t1", 2'b01, 2'b01, 1'b0, 32'h0, 1'b0, 4'd1, 4'd0);
        in_valid = '0;
        tick();
        check("t1.pulse", 32'(out_valid), 32'd0);

        // 2: signed BLT taken but predicted not taken; JAL on lane 1 gets squashed
        set_lane(0, BLT, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h280, 1'b0, 32'h0, 1'b1);
        set_lane(1, JAL, 32'd0, 32'd0, 32'h204, 32'h300, 1'b1, 32'h300, 1'b1);
        tick();
        check_out("t2", 2'b01, 2'b01, 1'b1, 32'h280, 1'b0, 4'd2, 4'd1);
        check("t2.ready_sq0", 32'(in_ready), 32'd0);
        // A valid, correctly predicted bundle waits at the input through the drain
        set_lane(0, BEQ, 32'd5, 32'd5, 32'h40, 32'h100, 1'b1, 32'h100, 1'b1);
        set_lane(1, ADD, 32'd0, 32'd0, 32'h44, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        check("t2.ready_sq1", 32'(in_ready), 32'd0);
        check_out("t2.drain1", 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 4'd2, 4'd1);
        tick();
        check("t2.ready_run", 32'(in_ready), 32'd1);
        check_out("t2.drain2", 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 4'd2, 4'd1);
        tick();
        check_out("t2.after", 2'b01, 2'b01, 1'b0, 32'h0, 1'b0, 4'd3, 4'd1);
        in_valid = '0;

        // 3: unsigned compares, lane 0 correct not taken, lane 1 BGEU taken mispredict
        set_lane(0, BLTU, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h500, 1'b0, 32'h0, 1'b1);
        set_lane(1, BGEU, 32'hFFFF_FFFF, 32'd1, 32'h404, 32'h600, 1'b0, 32'h0, 1'b1);
        tick();
        check_out("t3", 2'b11, 2'b10, 1'b1, 32'h600, 1'b1, 4'd5, 4'd2);
        in_valid = '0;
        tick();
        tick();
        check("t3.ready", 32'(in_ready), 32'd1);

        // BNE not taken correct; predicted-taken non-control lane redirects to pc+4
        set_lane(0, BNE, 32'd3, 32'd3, 32'h6F0, 32'h900, 1'b0, 32'h0, 1'b1);
        set_lane(1, ADD, 32'd1, 32'd2, 32'h700, 32'hABC, 1'b1, 32'hABC, 1'b1);
        tick();
        check_out("t3b", 2'b11, 2'b00, 1'b1, 32'h704, 1'b1, 4'd6, 4'd3);
        in_valid = '0;
        tick();
        tick();

        // Signed BGE taken with a wrong predicted target; lane 1 squashed
        set_lane(0, BGE, 32'd1, 32'hFFFF_FFFF, 32'h7F0, 32'h800, 1'b1, 32'h999, 1'b1);
        set_lane(1, BEQ, 32'd0, 32'd0, 32'h7F4, 32'h880, 1'b1, 32'h880, 1'b1);
        tick();
        check_out("t3c", 2'b01, 2'b01, 1'b1, 32'h800, 1'b0, 4'd7, 4'd4);
        in_valid = '0;
        tick();
        tick();

        // 4: stall holds off a valid bundle
        set_lane(0, BEQ, 32'd5, 32'd5, 32'h40, 32'h100, 1'b1, 32'h100, 1'b1);
        set_lane(1, ADD, 32'd0, 32'd0, 32'h44, 32'h0, 1'b0, 32'h0, 1'b0);
        stall = 1'b1;
        #1;
        check("t4.ready_stall", 32'(in_ready), 32'd0);
        tick();
        check_out("t4.stall", 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 4'd7, 4'd4);
        stall = 1'b0;
        tick();
        check_out("t4.release", 2'b01, 2'b01, 1'b0, 32'h0, 1'b0, 4'd8, 4'd4);

        // 6: br_count saturation with two control ops per cycle (BEQ not taken, JALR)
        set_lane(0, BEQ, 32'd1, 32'd2, 32'hA00, 32'hB00, 1'b0, 32'h0, 1'b1);
        set_lane(1, JALR, 32'd0, 32'd0, 32'hA04, 32'hC00, 1'b1, 32'hC00, 1'b1);
        tick();
        tick();
        tick();
        check_out("t6.14", 2'b11, 2'b10, 1'b0, 32'h0, 1'b0, 4'd14, 4'd4);
        tick();
        check("t6.clamp", 32'(br_count), 32'd15);
        tick();
        check("t6.hold", 32'(br_count), 32'd15);
        in_valid = '0;

        // 5: reset while draining
        set_lane(0, BLT, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h280, 1'b0, 32'h0, 1'b1);
        set_lane(1, JAL, 32'd0, 32'd0, 32'h204, 32'h300, 1'b1, 32'h300, 1'b1);
        tick();
        check("t5.redirect", 32'(redirect_valid), 32'd1);
        check("t5.mispred", 32'(mispred_count), 32'd5);
        check("t5.ready_sq", 32'(in_ready), 32'd0);
        in_valid = '0;
        rst = 1'b1;
        tick();
        check("t5.ready_run", 32'(in_ready), 32'd1);
        check_out("t5.reset", 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 4'd0, 4'd0);
        stall = 1'b1;
        #1;
        check("t5.ready_stall", 32'(in_ready), 32'd0);
        stall = 1'b0;
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
